// File: rtl/alu_uart_ctrl.sv
// Frame sequencer: collects A, B and opcode bytes from the UART, drives the ALU, and sends the result back.
// Optional inter-byte timeout in GET_B/GET_OP is enabled with `define ALU_CTRL_TIMEOUT_EN.
module alu_uart_ctrl #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_done,
  input  logic                  tx_done,
  input  logic [DATA_WIDTH-1:0] alu_w,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [DATA_WIDTH-1:0] alu_op,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_start,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [2:0] {
    GET_A,
    GET_B,
    GET_OP,
    EXEC,
    SEND,
    WAIT_TX,
    ERR
  } state_t;

  localparam logic [DATA_WIDTH-1:0] OP_ADD = DATA_WIDTH'(8'h20);
  localparam logic [DATA_WIDTH-1:0] OP_SUB = DATA_WIDTH'(8'h22);
  localparam logic [DATA_WIDTH-1:0] OP_AND = DATA_WIDTH'(8'h24);
  localparam logic [DATA_WIDTH-1:0] OP_OR  = DATA_WIDTH'(8'h25);
  localparam logic [DATA_WIDTH-1:0] OP_XOR = DATA_WIDTH'(8'h26);
  localparam logic [DATA_WIDTH-1:0] OP_NOR = DATA_WIDTH'(8'h27);
  localparam logic [DATA_WIDTH-1:0] OP_SRA = DATA_WIDTH'(8'h03);
  localparam logic [DATA_WIDTH-1:0] OP_SRL = DATA_WIDTH'(8'h02);

  state_t state, state_nx;
  logic   op_ok;
  logic   timeout;

  always_comb begin
    op_ok = 1'b0;
    case (rx_data)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRA, OP_SRL: op_ok = 1'b1;
      default:                        op_ok = 1'b0;
    endcase
  end

`ifdef ALU_CTRL_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] tcnt;
  logic          waiting;

  assign waiting = (state == GET_B) || (state == GET_OP);
  // Expiry fires on the TIMEOUT_CYCLES-th idle cycle; a coincident rx_done suppresses it.
  assign timeout = waiting && !rx_done && (tcnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else if (waiting && !rx_done && !timeout) begin
      tcnt <= tcnt + CW'(1);
    end else begin
      tcnt <= '0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= GET_A;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      GET_A: begin
        if (rx_done) state_nx = GET_B;
      end
      GET_B: begin
        if (rx_done)      state_nx = GET_OP;
        else if (timeout) state_nx = ERR;
      end
      GET_OP: begin
        if (rx_done)      state_nx = op_ok ? EXEC : ERR;
        else if (timeout) state_nx = ERR;
      end
      EXEC:    state_nx = SEND;
      SEND:    state_nx = WAIT_TX;
      WAIT_TX: begin
        if (tx_done) state_nx = GET_A;
      end
      ERR:     state_nx = GET_A;
      default: state_nx = GET_A;
    endcase
  end

  always_comb begin
    tx_start = (state == SEND);
    err      = (state == ERR);
    busy     = (state == EXEC) || (state == SEND) || (state == WAIT_TX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= '0;
      tx_data <= '0;
    end else begin
      if (rx_done) begin
        case (state)
          GET_A:   alu_a <= rx_data;
          GET_B:   alu_b <= rx_data;
          GET_OP:  if (op_ok) alu_op <= rx_data;
          default: ;
        endcase
      end
      if (state == EXEC) tx_data <= alu_w;
    end
  end

endmodule
